// File: rtl/johnson_ring_counter.sv
// Parametrised Johnson / one-hot ring sequence counter with direction, enable, load,
// decoded index, wrap pulse and illegal-state flag. Optional macro: JOHNSON_RING_SELF_CORRECT_EN.
module johnson_ring_counter #(
  parameter  int unsigned WIDTH = 4,
  localparam int unsigned IDX_W = $clog2(2 * WIDTH)
) (
  input  logic             jk_clk,
  input  logic             jk_rs,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [IDX_W-1:0] state_idx,
  output logic             wrap,
  output logic             illegal
);

  typedef enum logic {
    MODE_JOHNSON = 1'b0,
    MODE_RING    = 1'b1
  } mode_e;

  mode_e            mode_q;
  mode_e            mode_in;
  logic [WIDTH-1:0] q_p1;
  logic [WIDTH-1:0] qn_p1;
  logic             therm_lo;
  logic             therm_hi;
  logic             one_hot;
  int unsigned      pop;
  logic [IDX_W-1:0] ring_pos;
  logic [IDX_W-1:0] last_idx;
  logic [WIDTH-1:0] adv_q;
  logic             wrap_step;

  assign mode_in = mode_e'(mode);

  function automatic logic [WIDTH-1:0] start_of(input mode_e m);
    return (m == MODE_RING) ? WIDTH'(1) : '0;
  endfunction

  // Thermometer test: 0..01..1 is 2^k-1, and 1..10..0 is its complement.
  assign q_p1     = q + WIDTH'(1);
  assign qn_p1    = ~q + WIDTH'(1);
  assign therm_lo = ((q & q_p1) == '0);
  assign therm_hi = ((~q & qn_p1) == '0);
  assign one_hot  = (q != '0) && ((q & (q - WIDTH'(1))) == '0);

  always_comb begin
    pop      = 0;
    ring_pos = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (q[i]) begin
        pop      = pop + 1;
        ring_pos = IDX_W'(i);
      end
    end
  end

  always_comb begin
    illegal   = 1'b0;
    state_idx = '0;
    if (mode_q == MODE_RING) begin
      illegal = !one_hot;
      if (one_hot) state_idx = ring_pos;
    end else begin
      illegal = !(therm_lo || therm_hi);
      if (therm_lo || therm_hi)
        state_idx = q[WIDTH-1] ? IDX_W'(2 * WIDTH - pop) : IDX_W'(pop);
    end
  end

  assign last_idx = (mode_q == MODE_RING) ? IDX_W'(WIDTH - 1) : IDX_W'(2 * WIDTH - 1);

  always_comb begin
    adv_q = q;
    unique case ({mode_q, dir})
      {MODE_JOHNSON, 1'b0}: adv_q = {q[WIDTH-2:0], ~q[WIDTH-1]};
      {MODE_JOHNSON, 1'b1}: adv_q = {~q[0], q[WIDTH-1:1]};
      {MODE_RING,    1'b0}: adv_q = {q[WIDTH-2:0], q[WIDTH-1]};
      {MODE_RING,    1'b1}: adv_q = {q[0], q[WIDTH-1:1]};
      default:              adv_q = q;
    endcase
  end

  // Wrap is judged from the pre-step index; an illegal source never wraps.
  assign wrap_step = !illegal && (dir ? (state_idx == '0) : (state_idx == last_idx));

  always_ff @(posedge jk_clk) begin
    if (!jk_rs) begin
      mode_q <= mode_in;
      q      <= start_of(mode_in);
      wrap   <= 1'b0;
    end else if (mode_in != mode_q) begin
      mode_q <= mode_in;
      q      <= start_of(mode_in);
      wrap   <= 1'b0;
    end else if (load) begin
      q    <= load_val;
      wrap <= 1'b0;
    end else if (en) begin
`ifdef JOHNSON_RING_SELF_CORRECT_EN
      q    <= illegal ? start_of(mode_q) : adv_q;
`else
      q    <= adv_q;
`endif
      wrap <= wrap_step;
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_johnson_ring_counter.sv
// Table-driven bench for johnson_ring_counter at WIDTH=4; expectations follow
// JOHNSON_RING_SELF_CORRECT_EN when it is defined.
module tb_johnson_ring_counter;

  localparam int unsigned W  = 4;
  localparam int unsigned IW = 3;

  logic          jk_clk = 1'b0;
  logic          jk_rs, en, mode, dir, load;
  logic [W-1:0]  load_val;
  logic [W-1:0]  q;
  logic [IW-1:0] state_idx;
  logic          wrap, illegal;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic          rs, md, e, d, ld;
    logic [W-1:0]  lv;
    logic [W-1:0]  xq;
    logic [IW-1:0] xidx;
    logic          xwrap, xill;
  } vec_t;

  vec_t vecs[$];

  johnson_ring_counter #(.WIDTH(W)) dut (
    .jk_clk   (jk_clk),
    .jk_rs    (jk_rs),
    .en       (en),
    .mode     (mode),
    .dir      (dir),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .state_idx(state_idx),
    .wrap     (wrap),
    .illegal  (illegal)
  );

  always #5 jk_clk = ~jk_clk;

  task automatic add(input logic rs, md, e, d, ld, input logic [W-1:0] lv,
                     input logic [W-1:0] xq, input logic [IW-1:0] xidx,
                     input logic xwrap, xill);
    vec_t v;
    v.rs = rs; v.md = md; v.e = e; v.d = d; v.ld = ld; v.lv = lv;
    v.xq = xq; v.xidx = xidx; v.xwrap = xwrap; v.xill = xill;
    vecs.push_back(v);
  endtask

  task automatic cmp(input string name, input int idx, input logic [31:0] got, exp);
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, got, exp);
    end
  endtask

  task automatic check_all(input int idx, input vec_t v);
    n_vec++;
    cmp("q",         idx, 32'(q),         32'(v.xq));
    cmp("state_idx", idx, 32'(state_idx), 32'(v.xidx));
    cmp("wrap",      idx, 32'(wrap),      32'(v.xwrap));
    cmp("illegal",   idx, 32'(illegal),   32'(v.xill));
  endtask

  initial begin
    vec_t v;
    jk_rs = 1'b0; en = 1'b0; mode = 1'b0; dir = 1'b0; load = 1'b0; load_val = '0;

    //  rs md en dr ld  lv        q         idx  wr il
    // Johnson up through a full lap with wrap at 0000
    add(0, 0, 1, 0, 0, 4'b0000, 4'b0000, 3'd0, 0, 0);
    add(1, 0, 1, 0, 0, 4'b0000, 4'b0001, 3'd1, 0, 0);
    add(1, 0, 1, 0, 0, 4'b0000, 4'b0011, 3'd2, 0, 0);
    add(1, 0, 1, 0, 0, 4'b0000, 4'b0111, 3'd3, 0, 0);
    add(1, 0, 1, 0, 0, 4'b0000, 4'b1111, 3'd4, 0, 0);
    add(1, 0, 1, 0, 0, 4'b0000, 4'b1110, 3'd5, 0, 0);
    add(1, 0, 1, 0, 0, 4'b0000, 4'b1100, 3'd6, 0, 0);
    add(1, 0, 1, 0, 0, 4'b0000, 4'b1000, 3'd7, 0, 0);
    add(1, 0, 1, 0, 0, 4'b0000, 4'b0000, 3'd0, 1, 0);
    add(1, 0, 1, 0, 0, 4'b0000, 4'b0001, 3'd1, 0, 0);
    // sync reset at 1110 with en and load both high
    add(1, 0, 1, 0, 0, 4'b0000, 4'b0011, 3'd2, 0, 0);
    add(1, 0, 1, 0, 0, 4'b0000, 4'b0111, 3'd3, 0, 0);
    add(1, 0, 1, 0, 0, 4'b0000, 4'b1111, 3'd4, 0, 0);
    add(1, 0, 1, 0, 0, 4'b0000, 4'b1110, 3'd5, 0, 0);
    add(0, 0, 1, 0, 1, 4'b1010, 4'b0000, 3'd0, 0, 0);
    // hold at 0011 with dir toggling
    add(1, 0, 1, 0, 0, 4'b0000, 4'b0001, 3'd1, 0, 0);
    add(1, 0, 1, 0, 0, 4'b0000, 4'b0011, 3'd2, 0, 0);
    add(1, 0, 0, 1, 0, 4'b0000, 4'b0011, 3'd2, 0, 0);
    add(1, 0, 0, 0, 0, 4'b0000, 4'b0011, 3'd2, 0, 0);
    add(1, 0, 0, 1, 0, 4'b0000, 4'b0011, 3'd2, 0, 0);
    add(1, 0, 0, 0, 0, 4'b0000, 4'b0011, 3'd2, 0, 0);
    add(1, 0, 0, 1, 0, 4'b0000, 4'b0011, 3'd2, 0, 0);
    // load beats en; mode change beats load
    add(1, 0, 1, 0, 0, 4'b0000, 4'b0111, 3'd3, 0, 0);
    add(1, 0, 1, 0, 1, 4'b1100, 4'b1100, 3'd6, 0, 0);
    add(1, 0, 0, 0, 0, 4'b0000, 4'b1100, 3'd6, 0, 0);
    add(1, 1, 1, 0, 1, 4'b0100, 4'b0001, 3'd0, 0, 0);
    add(1, 1, 1, 0, 0, 4'b0000, 4'b0010, 3'd1, 0, 0);
    // ring down and up wraps
    add(1, 1, 1, 1, 0, 4'b0000, 4'b0001, 3'd0, 0, 0);
    add(1, 1, 1, 1, 0, 4'b0000, 4'b1000, 3'd3, 1, 0);
    add(1, 1, 1, 1, 0, 4'b0000, 4'b0100, 3'd2, 0, 0);
    add(1, 1, 1, 1, 0, 4'b0000, 4'b0010, 3'd1, 0, 0);
    add(1, 1, 1, 1, 0, 4'b0000, 4'b0001, 3'd0, 0, 0);
    add(1, 1, 1, 1, 0, 4'b0000, 4'b1000, 3'd3, 1, 0);
    add(1, 1, 1, 0, 0, 4'b0000, 4'b0001, 3'd0, 1, 0);
    // Johnson down wrap, immediate direction reversal
    add(1, 0, 1, 1, 0, 4'b0000, 4'b0000, 3'd0, 0, 0);
    add(1, 0, 1, 1, 0, 4'b0000, 4'b1000, 3'd7, 1, 0);
    add(1, 0, 1, 0, 0, 4'b0000, 4'b0000, 3'd0, 1, 0);
    add(1, 0, 1, 1, 0, 4'b0000, 4'b1000, 3'd7, 1, 0);
    add(1, 0, 1, 1, 0, 4'b0000, 4'b1100, 3'd6, 0, 0);
    // illegal Johnson load
    add(1, 0, 0, 0, 1, 4'b0101, 4'b0101, 3'd0, 0, 1);
`ifdef JOHNSON_RING_SELF_CORRECT_EN
    add(1, 0, 1, 0, 0, 4'b0000, 4'b0000, 3'd0, 0, 0);
    add(1, 0, 1, 0, 0, 4'b0000, 4'b0001, 3'd1, 0, 0);
`else
    add(1, 0, 1, 0, 0, 4'b0000, 4'b1011, 3'd0, 0, 1);
    add(1, 0, 1, 0, 0, 4'b0000, 4'b0110, 3'd0, 0, 1);
`endif
    // illegal ring load
    add(1, 1, 0, 0, 0, 4'b0000, 4'b0001, 3'd0, 0, 0);
    add(1, 1, 0, 0, 1, 4'b0110, 4'b0110, 3'd0, 0, 1);
`ifdef JOHNSON_RING_SELF_CORRECT_EN
    add(1, 1, 1, 0, 0, 4'b0000, 4'b0001, 3'd0, 0, 0);
`else
    add(1, 1, 1, 0, 0, 4'b0000, 4'b1100, 3'd0, 0, 1);
`endif
    // back to a known Johnson state for the async-pulse check
    add(0, 0, 0, 0, 0, 4'b0000, 4'b0000, 3'd0, 0, 0);
    add(1, 0, 1, 0, 0, 4'b0000, 4'b0001, 3'd1, 0, 0);
    add(1, 0, 1, 0, 0, 4'b0000, 4'b0011, 3'd2, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(negedge jk_clk);
      jk_rs = v.rs; mode = v.md; en = v.e; dir = v.d; load = v.ld; load_val = v.lv;
      @(posedge jk_clk);
      #1;
      check_all(i, v);
    end

    // A reset glitch between edges must not disturb the synchronous reset.
    @(negedge jk_clk);
    en = 1'b0; load = 1'b0;
    #1 jk_rs = 1'b0;
    #2 jk_rs = 1'b1;
    @(posedge jk_clk);
    #1;
    v.xq = 4'b0011; v.xidx = 3'd2; v.xwrap = 1'b0; v.xill = 1'b0;
    check_all(1000, v);

    // One more enabled step shows the counter kept running from 0011.
    @(negedge jk_clk);
    en = 1'b1;
    @(posedge jk_clk);
    #1;
    v.xq = 4'b0111; v.xidx = 3'd3;
    check_all(1001, v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
